// File: rtl/switch_transpose_pkg.sv
// Shared defaults and coordinate helper for the transpose switch.
// The same helper gives the source index of a routed element and the
// destination of a captured element, because a row/column swap undoes itself.
package switch_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ROWS_DEF   = 4;
  localparam int COLS_DEF   = 4;

  typedef struct packed {
    int row;
    int col;
  } coord_t;

  // Swap row and column when ctrl selects transpose; otherwise keep them.
  function automatic coord_t swap_coord(input logic ctrl, input int row, input int col);
    coord_t c;
    if (ctrl) begin
      c.row = col;
      c.col = row;
    end else begin
      c.row = row;
      c.col = col;
    end
    return c;
  endfunction

endpackage

// File: rtl/switch_transpose_if.sv
// Matrix request/result bundle for the transpose switch.
// The master drives a matrix with ctrl and in_val; the slave returns
// the routed matrix with out_val.
interface switch_transpose_if
  import switch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int COLS   = COLS_DEF
) ();

  logic              ctrl;
  logic              in_val;
  logic [DATA_W-1:0] in_matrix  [ROWS][COLS];
  logic [DATA_W-1:0] out_matrix [ROWS][COLS];
  logic              out_val;

  modport master (
    output ctrl,
    output in_val,
    output in_matrix,
    input  out_matrix,
    input  out_val
  );

  modport slave (
    input  ctrl,
    input  in_val,
    input  in_matrix,
    output out_matrix,
    output out_val
  );

endinterface

// File: rtl/switch_transpose_cell.sv
// One grid cell of the transpose switch.
// The cell owns the element at (ROW_IDX, COL_IDX). It picks that element
// from the down path (column) or the across path (row), then places it in
// the column slot it lands on. Every other slot is zero, so the top can
// OR-merge the cells.
module switch_cell
  import switch_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int ROW_IDX = 0,
  parameter int COL_IDX = 0
) (
  input  logic [DATA_W-1:0] in_elements_down   [COLS],
  input  logic [DATA_W-1:0] in_elements_across [COLS],
  input  logic              ctrl,
  output logic [DATA_W-1:0] out_elements       [COLS]
);

  logic [DATA_W-1:0] elem_s;
  coord_t            dest_s;

  // Select this cell's element: down[ROW_IDX] when transposing, across[COL_IDX] otherwise.
  always_comb begin
    elem_s = '0;
    for (int c = 0; c < COLS; c++) begin
      elem_s = elem_s | (ctrl ? ((c == ROW_IDX) ? in_elements_down[c]   : '0)
                              : ((c == COL_IDX) ? in_elements_across[c] : '0));
    end
  end

  // Place the element at its destination column and zero-fill the other columns.
  always_comb begin
    dest_s = swap_coord(ctrl, ROW_IDX, COL_IDX);
    for (int c = 0; c < COLS; c++) begin
      out_elements[c] = (c == dest_s.col) ? elem_s : '0;
    end
  end

endmodule

// File: rtl/switch_transpose.sv
// Matrix transpose / pass-through switch with a two-register pipeline.
// Stage 1 captures the matrix and ctrl on in_val. A combinational grid of
// switch cells builds one partial matrix per input row, and the partials
// are OR-merged. Stage 2 registers the merged matrix on every edge. out_val
// follows in_val through a two-stage valid pipe.
module switch_transpose
  import switch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int COLS   = COLS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  switch_transpose_if.slave bus
);

  if (ROWS != COLS) begin : g_bad_shape
    $fatal(1, "switch_transpose: ROWS must equal COLS");
  end

  logic [DATA_W-1:0] input_elements_r  [ROWS][COLS];
  logic              ctrl_r;
  logic              v1_r;
  logic [DATA_W-1:0] cell_out_s        [ROWS][COLS][COLS];
  logic [DATA_W-1:0] outputs_s         [ROWS][ROWS][COLS];
  logic [DATA_W-1:0] routed_s          [ROWS][COLS];
  logic [DATA_W-1:0] out_matrix_r      [ROWS][COLS];
  logic [DATA_W-1:0] output_elements_s [ROWS][COLS];
  logic              out_val_r;

  // Stage 1: capture the matrix and routing select when in_val is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      input_elements_r <= '{default: '0};
      ctrl_r           <= 1'b0;
    end else if (bus.in_val) begin
      input_elements_r <= bus.in_matrix;
      ctrl_r           <= bus.ctrl;
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_in_i
    for (genvar j = 0; j < COLS; j++) begin : g_in_j
      logic [DATA_W-1:0] down_s   [COLS];
      logic [DATA_W-1:0] across_s [COLS];
      logic [DATA_W-1:0] cell_o_s [COLS];

      for (genvar c = 0; c < COLS; c++) begin : g_c
        assign down_s[c]            = input_elements_r[c][j];
        assign across_s[c]          = input_elements_r[i][c];
        assign cell_out_s[i][j][c]  = cell_o_s[c];
      end

      switch_cell #(
        .DATA_W  (DATA_W),
        .COLS    (COLS),
        .ROW_IDX (i),
        .COL_IDX (j)
      ) ss (
        .in_elements_down   (down_s),
        .in_elements_across (across_s),
        .ctrl               (ctrl_r),
        .out_elements       (cell_o_s)
      );
    end
  end

  // Build one partial matrix per input row from that row's cells, then OR-merge the partials.
  always_comb begin
    coord_t d;
    outputs_s = '{default: '0};
    routed_s  = '{default: '0};
    for (int k = 0; k < ROWS; k++) begin
      for (int j = 0; j < COLS; j++) begin
        d = swap_coord(ctrl_r, k, j);
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            outputs_s[k][r][c] = outputs_s[k][r][c] |
                                 ((d.row == r) ? cell_out_s[k][j][c] : '0);
          end
        end
      end
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          routed_s[r][c] = routed_s[r][c] | outputs_s[k][r][c];
        end
      end
    end
  end

  // Stage 2: register the routed matrix every cycle and advance the valid pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_matrix_r <= '{default: '0};
      v1_r         <= 1'b0;
      out_val_r    <= 1'b0;
    end else begin
      out_matrix_r <= routed_s;
      v1_r         <= bus.in_val;
      out_val_r    <= v1_r;
    end
  end

  assign output_elements_s = out_matrix_r;
  assign bus.out_matrix    = output_elements_s;
  assign bus.out_val       = out_val_r;

endmodule

// File: tb/tb_switch_transpose.sv
// Directed bench for switch_transpose: reset, transpose, pass-through,
// per-row partials, streaming with alternating ctrl, hold, and mid-stream reset.
module tb_switch_transpose;
  import switch_pkg::*;

  localparam int DW = 8;
  localparam int N  = 4;
  typedef logic [DW-1:0] mat_t [N][N];

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  mat_t base_m;
  mat_t zero_m;
  mat_t exp_m;
  mat_t stream_m [6];
  logic stream_c [6];

  switch_transpose_if #(.DATA_W(DW), .ROWS(N), .COLS(N)) bus ();

  switch_transpose #(.DATA_W(DW), .ROWS(N), .COLS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_mat(input string tag, input mat_t exp);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check_val($sformatf("%s[%0d][%0d]", tag, i, j),
                  32'(bus.out_matrix[i][j]), 32'(exp[i][j]));
  endtask

  // Expected routing: transpose swaps row and column, pass-through keeps them.
  function automatic mat_t expect_route(input mat_t m, input logic c);
    mat_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[i][j] = c ? m[j][i] : m[i][j];
    return r;
  endfunction

  task automatic drive(input mat_t m, input logic c, input logic v);
    bus.in_matrix = m;
    bus.ctrl      = c;
    bus.in_val    = v;
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        base_m[i][j] = 8'(8'h10 * i + 8'h0A + j);
        zero_m[i][j] = 8'h00;
      end
    for (int k = 0; k < 6; k++) begin
      stream_c[k] = (k % 2 == 0) ? 1'b1 : 1'b0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          stream_m[k][i][j] = 8'(8'h40 * k + 8'h10 * i + j + 8'h03);
    end

    // Reset with ctrl=1 and in_val=0.
    rst = 1'b1;
    drive(zero_m, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check_val("reset_out_val", 32'(bus.out_val), 32'd0);
    check_mat("reset_out", zero_m);

    // Transpose of the base matrix.
    rst = 1'b0;
    drive(base_m, 1'b1, 1'b1);
    @(negedge clk);
    check_val("latency_not_yet", 32'(bus.out_val), 32'd0);
    @(negedge clk);
    check_val("tr_out_val", 32'(bus.out_val), 32'd1);
    for (int j = 0; j < N; j++) begin
      check_val($sformatf("tr_row0_%0d", j), 32'(bus.out_matrix[0][j]), 32'(8'h10 * j + 8'h0A));
      check_val($sformatf("tr_row3_%0d", j), 32'(bus.out_matrix[3][j]), 32'(8'h10 * j + 8'h0D));
    end
    check_val("tr_01", 32'(bus.out_matrix[0][1]), 32'h1A);
    check_val("tr_10", 32'(bus.out_matrix[1][0]), 32'h0B);
    @(negedge clk);
    check_val("tr_hold_out_val", 32'(bus.out_val), 32'd1);
    check_mat("tr_hold", expect_route(base_m, 1'b1));

    // Per-row partials: row 1 lands in column 1 only; merged partials give the transpose.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        check_val($sformatf("part1[%0d][%0d]", r, c), 32'(dut.outputs_s[1][r][c]),
                  (c == 1) ? 32'(8'h1A + r) : 32'h0);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        logic [DW-1:0] acc;
        acc = '0;
        for (int k = 0; k < N; k++) acc = acc | dut.outputs_s[k][r][c];
        check_val($sformatf("part_or[%0d][%0d]", r, c), 32'(acc), 32'(base_m[c][r]));
      end

    // Pass-through of the same data.
    drive(base_m, 1'b0, 1'b1);
    @(negedge clk);
    check_val("order_still_tr", 32'(bus.out_matrix[0][1]), 32'h1A);
    @(negedge clk);
    check_val("pt_out_val", 32'(bus.out_val), 32'd1);
    check_mat("pt", base_m);

    // Streaming: consecutive matrices with alternating ctrl, then in_val drops.
    for (int k = 0; k < 8; k++) begin
      if (k >= 2) begin
        check_val($sformatf("st%0d_val", k - 2), 32'(bus.out_val), 32'd1);
        check_mat($sformatf("st%0d", k - 2), expect_route(stream_m[k - 2], stream_c[k - 2]));
      end
      if (k < 6) drive(stream_m[k], stream_c[k], 1'b1);
      else       drive(stream_m[5], stream_c[5], 1'b0);
      @(negedge clk);
    end

    // Hold: out_val has fallen, last result and captured input persist.
    check_val("hold_out_val", 32'(bus.out_val), 32'd0);
    exp_m = expect_route(stream_m[5], stream_c[5]);
    check_mat("hold_out", exp_m);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check_val($sformatf("hold_in[%0d][%0d]", i, j),
                  32'(dut.input_elements_r[i][j]), 32'(stream_m[5][i][j]));

    // Mid-stream asynchronous reset.
    drive(base_m, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check_val("pre_rst_out_val", 32'(bus.out_val), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_out_val", 32'(bus.out_val), 32'd0);
    check_val("async_rst_out23", 32'(bus.out_matrix[2][3]), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    drive(base_m, 1'b1, 1'b0);
    @(negedge clk);
    check_val("post_rst_out_val", 32'(bus.out_val), 32'd0);
    check_val("post_rst_out00", 32'(bus.out_matrix[0][0]), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
